// File: rtl/seq_word_serializer.sv
// Parallel-to-serial word front end for the 1011 detector; MSB first by default, LSB first when SER_LSB_FIRST_EN is defined.
// Latency: bit 0 is valid (with first) the cycle after the load edge; back-to-back words stream with no bubble.
// Backpressure: bit_ready low holds bit_out/first/last; load_ready is combinational from bit_ready on the last bit.
module seq_word_serializer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             first,
    output logic             last,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    count;
    logic             first_q;
    logic             head;
    logic             at_last;
    logic             xfer;
    logic             load;

`ifdef SER_LSB_FIRST_EN
    assign head = sreg[0];
`else
    assign head = sreg[WIDTH-1];
`endif

    assign busy       = (state == SHIFT);
    assign bit_valid  = busy;
    assign at_last    = busy && (count == '0);
    assign last       = at_last;
    assign first      = first_q;
    // Gate with busy so a drained register never leaks stale bits while idle
    assign bit_out    = busy & head;
    assign xfer       = bit_valid && bit_ready;
    assign load_ready = !busy || (xfer && at_last);
    assign load       = load_valid && load_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sreg    <= '0;
            count   <= '0;
            first_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        sreg    <= load_data;
                        count   <= CW'(WIDTH - 1);
                        first_q <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (xfer) begin
                        if (count != '0) begin
`ifdef SER_LSB_FIRST_EN
                            sreg <= sreg >> 1;
`else
                            sreg <= sreg << 1;
`endif
                            count   <= count - 1'b1;
                            first_q <= 1'b0;
                        end else if (load) begin
                            sreg    <= load_data;
                            count   <= CW'(WIDTH - 1);
                            first_q <= 1'b1;
                        end else begin
                            first_q <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_word_serializer.sv
// Directed bench for seq_word_serializer: scoreboard of expected {bit, first, last} per serial transfer.
module tb_seq_word_serializer;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] load_data;
    logic         bit_out;
    logic         bit_valid;
    logic         bit_ready;
    logic         first;
    logic         last;
    logic         busy;

    logic         w1_load_valid;
    logic         w1_load_ready;
    logic [0:0]   w1_load_data;
    logic         w1_bit_out;
    logic         w1_bit_valid;
    logic         w1_first;
    logic         w1_last;
    logic         w1_busy;

    int tests = 0;
    int fails = 0;
    logic [2:0] q[$];
    logic acc;

    always #5 clk = ~clk;

    seq_word_serializer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .bit_out(bit_out), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .first(first), .last(last), .busy(busy)
    );

    seq_word_serializer #(.WIDTH(1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .load_valid(w1_load_valid), .load_ready(w1_load_ready),
        .load_data(w1_load_data), .bit_out(w1_bit_out), .bit_valid(w1_bit_valid),
        .bit_ready(1'b1), .first(w1_first), .last(w1_last), .busy(w1_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [W-1:0] d);
        for (int i = 0; i < W; i++) begin
`ifdef SER_LSB_FIRST_EN
            q.push_back({d[i], i == 0, i == W - 1});
`else
            q.push_back({d[W-1-i], i == 0, i == W - 1});
`endif
        end
    endtask

    // One clock: check outputs against the model at negedge, then advance past the posedge.
    task automatic tick(output logic accepted);
        logic xfer_m;
        logic lr_m;
        @(negedge clk);
        xfer_m = (q.size() != 0) && bit_ready;
        lr_m   = (q.size() == 0) || (xfer_m && q[0][0]);
        chk("bit_valid", 32'(bit_valid), 32'(q.size() != 0));
        chk("busy", 32'(busy), 32'(q.size() != 0));
        chk("load_ready", 32'(load_ready), 32'(lr_m));
        if (q.size() != 0)
            chk("bit_first_last", 32'({bit_out, first, last}), 32'(q[0]));
        if (xfer_m)
            void'(q.pop_front());
        accepted = load_valid && lr_m;
        if (accepted)
            push_word(load_data);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 500 && q.size() != 0; n++)
            tick(acc);
        chk(tag, 32'(q.size()), 32'd0);
    endtask

    task automatic load_word(input logic [W-1:0] d);
        load_valid = 1'b1;
        load_data  = d;
        tick(acc);
        chk("load_accept", 32'(acc), 32'd1);
        load_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_bit_out"}, 32'(bit_out), 32'd0);
        chk({tag, "_bit_valid"}, 32'(bit_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_first"}, 32'(first), 32'd0);
        chk({tag, "_last"}, 32'(last), 32'd0);
        chk({tag, "_load_ready"}, 32'(load_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        load_valid = 1'b0;
        load_data = '0;
        bit_ready = 1'b1;
        w1_load_valid = 1'b0;
        w1_load_data = 1'b0;
        #12;
        chk_reset_vals("reset");
        chk("w1_reset_valid", 32'(w1_bit_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic word
        load_word(32'hBB60_A0AD);
        drain("basic_drain");
        tick(acc);
        chk("basic_idle_busy", 32'(busy), 32'd0);

        // Back-to-back: second word offered while the first streams
        load_valid = 1'b1;
        load_data  = 32'hBB60_A0AD;
        tick(acc);
        chk("b2b_first_accept", 32'(acc), 32'd1);
        load_data = 32'h0000_000B;
        acc = 1'b0;
        for (int n = 0; n < 100 && !acc; n++)
            tick(acc);
        chk("b2b_second_accept", 32'(acc), 32'd1);
        chk("b2b_queue_depth", 32'(q.size()), 32'(W));
        load_valid = 1'b0;
        drain("b2b_drain");

        // Backpressure
        load_word(32'hA5A5_A5A5);
        for (int n = 0; n < 500 && q.size() != 0; n++) begin
            bit_ready = 1'($urandom_range(0, 1));
            tick(acc);
        end
        chk("bp_drain", 32'(q.size()), 32'd0);
        bit_ready = 1'b1;
        tick(acc);

        // Load offered during bit 5 must be refused
        load_word(32'h0F0F_1234);
        for (int n = 0; n < 5; n++)
            tick(acc);
        load_valid = 1'b1;
        load_data  = 32'hFFFF_FFFF;
        tick(acc);
        chk("busy_load_refused", 32'(acc), 32'd0);
        load_valid = 1'b0;
        drain("busy_drain");

        // Reset mid-word
        load_word(32'hFFFF_FFFF);
        for (int n = 0; n < 10; n++)
            tick(acc);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        load_word(32'h0000_0001);
        drain("post_reset_drain");

        // WIDTH=1 instance: loads 1, 0, 1 back-to-back
        w1_load_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w1_load_data = (i == 1) ? 1'b0 : 1'b1;
            @(negedge clk);
            chk("w1_load_ready", 32'(w1_load_ready), 32'd1);
            @(posedge clk);
            #1;
            chk("w1_bit", 32'({w1_bit_valid, w1_bit_out, w1_first, w1_last}),
                32'({1'b1, (i == 1) ? 1'b0 : 1'b1, 1'b1, 1'b1}));
        end
        w1_load_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("w1_idle", 32'({w1_bit_valid, w1_busy}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
